frame_byte_streamer: RTL and testbench

FRAME_BYTE_STREAMER -- requirements
Module: frame_byte_streamer

---
 rtl/frame_byte_streamer_if.sv | 27 ++
 rtl/frame_byte_streamer.sv | 100 ++++++++++
 tb/tb_frame_byte_streamer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/frame_byte_streamer_if.sv
// Frame-buffer read port, UART byte handshake and frame status for frame_byte_streamer.
// master = streamer side, slave = buffer/transmitter side.
interface frame_byte_streamer_if #(
  parameter int FRAME_BYTES = 5100
);
  localparam int AW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  logic          frame_tick;
  logic [AW-1:0] rAddr;
  logic [7:0]    rData;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          frame_done;
  logic          frame_drop;

  modport master (
    input  frame_tick, rData, tx_ready,
    output rAddr, tx_data, tx_valid, busy, frame_done, frame_drop
  );

  modport slave (
    output frame_tick, rData, tx_ready,
    input  rAddr, tx_data, tx_valid, busy, frame_done, frame_drop
  );
endinterface

// File: rtl/frame_byte_streamer.sv
// Streams one frame buffer out as SOF0, SOF1, FRAME_BYTES data bytes and an XOR checksum.
// Every data byte takes READ/LOAD/SEND, matching the one-cycle buffer read latency.
module frame_byte_streamer #(
  parameter int         FRAME_BYTES = 5100,
  parameter logic [7:0] SOF0        = 8'hAA,
  parameter logic [7:0] SOF1        = 8'h55
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  frame_byte_streamer_if.master bus
);
  localparam int AW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, SOF_A, SOF_B, READ, LOAD, SEND, CSUM, DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_csum;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_drop;
  logic          w_hs;

  assign w_hs           = r_tx_valid & bus.tx_ready;
  assign bus.rAddr      = r_idx;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign bus.frame_drop = r_drop;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_csum     <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Ticks are never queued; outside IDLE (DONE included) they only flag a drop.
      r_drop <= bus.frame_tick && (r_state != IDLE);
      case (r_state)
        IDLE: if (bus.frame_tick) begin
          r_idx      <= '0;
          r_csum     <= 8'h00;
          r_busy     <= 1'b1;
          r_tx_data  <= SOF0;
          r_tx_valid <= 1'b1;
          r_state    <= SOF_A;
        end
        SOF_A: if (w_hs) begin
          r_tx_data <= SOF1;
          r_state   <= SOF_B;
        end
        SOF_B: if (w_hs) begin
          r_tx_valid <= 1'b0;
          r_state    <= READ;
        end
        READ: r_state <= LOAD;
        LOAD: begin
          r_tx_data  <= bus.rData;
          r_csum     <= r_csum ^ bus.rData;
          r_tx_valid <= 1'b1;
          r_state    <= SEND;
        end
        SEND: if (w_hs) begin
          if (r_idx == LAST_IDX) begin
            // r_csum already folds in the byte just accepted.
            r_tx_data <= r_csum;
            r_state   <= CSUM;
          end else begin
            r_idx      <= r_idx + AW'(1);
            r_tx_valid <= 1'b0;
            r_state    <= READ;
          end
        end
        CSUM: if (w_hs) begin
          r_tx_valid <= 1'b0;
          r_state    <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_byte_streamer.sv
// Directed bench: 4-byte frame under several ready/tick patterns, a mid-frame reset,
// and a full-size 5100-byte frame against an XOR model.
module tb_frame_byte_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_byte_streamer_if #(.FRAME_BYTES(4))    if4();
  frame_byte_streamer_if #(.FRAME_BYTES(5100)) ifk();

  frame_byte_streamer #(.FRAME_BYTES(4))    u_dut4 (.i_clk(clk), .i_reset(rst_n), .bus(if4));
  frame_byte_streamer #(.FRAME_BYTES(5100)) u_dutk (.i_clk(clk), .i_reset(rst_n), .bus(ifk));

  logic [7:0] mem4 [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [7:0] memk [5100];
  logic [7:0] e4   [7] = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};

  always @(posedge clk) begin
    if4.rData <= mem4[if4.rAddr];
    ifk.rData <= memk[ifk.rAddr];
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Negedge monitors: transferred bytes, status pulses, stall stability, max address.
  logic [7:0] q4[$], qk[$];
  int done4 = 0, drop4 = 0, stab4 = 0, donek = 0, maxk = 0;
  initial begin
    bit pst;
    logic [7:0] pd;
    pst = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) pst = 1'b0;
      else begin
        if (pst && !(if4.tx_valid && if4.tx_data == pd)) stab4++;
        pst = if4.tx_valid && !if4.tx_ready;
        pd  = if4.tx_data;
        if (if4.tx_valid && if4.tx_ready) q4.push_back(if4.tx_data);
        if (if4.frame_done) done4++;
        if (if4.frame_drop) drop4++;
        if (ifk.tx_valid && ifk.tx_ready) qk.push_back(ifk.tx_data);
        if (ifk.frame_done) donek++;
        if (int'(ifk.rAddr) > maxk) maxk = int'(ifk.rAddr);
      end
    end
  end

  task automatic run4(input bit tog, input bit mid, input bit indone, input int exp_drop,
                      input string tg);
    int b, d0, p0, s0, cyc;
    bit fired;
    b = q4.size(); d0 = done4; p0 = drop4; s0 = stab4; fired = 1'b0;
    @(posedge clk); #1;
    if4.tx_ready   = tog ? 1'b0 : 1'b1;
    if4.frame_tick = 1'b1;
    @(posedge clk); #1;
    if4.frame_tick = 1'b0;
    chk({tg, "_lat_valid"}, 32'(if4.tx_valid), 1);
    chk({tg, "_lat_sof0"},  32'(if4.tx_data), 32'hAA);
    cyc = 0;
    while (done4 == d0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (tog) if4.tx_ready = ~if4.tx_ready;
      if4.frame_tick = 1'b0;
      if (!fired && ((mid && q4.size() - b == 4) || (indone && q4.size() - b == 7))) begin
        if4.frame_tick = 1'b1;
        fired = 1'b1;
      end
    end
    if4.frame_tick = 1'b0;
    if4.tx_ready   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tg, "_done_cnt"}, done4 - d0, 1);
    chk({tg, "_nbytes"}, q4.size() - b, 7);
    if (q4.size() - b >= 7)
      for (int i = 0; i < 7; i++) chk($sformatf("%s_byte%0d", tg, i), 32'(q4[b+i]), 32'(e4[i]));
    chk({tg, "_drop_cnt"}, drop4 - p0, exp_drop);
    chk({tg, "_stall_stable"}, stab4 - s0, 0);
    chk({tg, "_busy_after"}, 32'(if4.busy), 0);
    chk({tg, "_idle_valid"}, 32'(if4.tx_valid), 0);
    chk({tg, "_idle_raddr"}, 32'(if4.rAddr), 0);
  endtask

  initial begin
    logic [7:0] xk;
    int b, d0, cyc, bad;
    xk = 8'h00;
    for (int i = 0; i < 5100; i++) begin
      memk[i] = i[7:0];
      xk ^= i[7:0];
    end
    if4.frame_tick = 1'b0; if4.tx_ready = 1'b0;
    ifk.frame_tick = 1'b0; ifk.tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(if4.tx_valid), 0);
    chk("rst_data",  32'(if4.tx_data), 0);
    chk("rst_busy",  32'(if4.busy), 0);
    chk("rst_done",  32'(if4.frame_done), 0);
    chk("rst_drop",  32'(if4.frame_drop), 0);
    chk("rst_raddr", 32'(if4.rAddr), 0);
    rst_n = 1'b1;

    run4(1'b0, 1'b0, 1'b0, 0, "rdy1");
    run4(1'b1, 1'b0, 1'b0, 0, "toggle");
    run4(1'b0, 1'b1, 1'b0, 1, "midtick");
    run4(1'b0, 1'b0, 1'b1, 1, "donetick");

    // Abort after the third accepted byte.
    b = q4.size(); d0 = done4;
    @(posedge clk); #1;
    if4.tx_ready = 1'b1; if4.frame_tick = 1'b1;
    @(posedge clk); #1;
    if4.frame_tick = 1'b0;
    cyc = 0;
    while (q4.size() - b < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reached", q4.size() - b, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(if4.tx_valid), 0);
    chk("abort_busy",  32'(if4.busy), 0);
    chk("abort_raddr", 32'(if4.rAddr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", done4 - d0, 0);
    run4(1'b0, 1'b0, 1'b0, 0, "restart");

    // Full-size frame.
    b = qk.size(); d0 = donek;
    @(posedge clk); #1;
    ifk.tx_ready = 1'b1; ifk.frame_tick = 1'b1;
    @(posedge clk); #1;
    ifk.frame_tick = 1'b0;
    cyc = 0;
    while (donek == d0 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("big_done", donek - d0, 1);
    chk("big_nbytes", qk.size() - b, 5103);
    chk("big_maxaddr", maxk, 5099);
    if (qk.size() - b >= 5103) begin
      chk("big_sof0", 32'(qk[b]), 32'hAA);
      chk("big_sof1", 32'(qk[b+1]), 32'h55);
      chk("big_last_data", 32'(qk[b+5101]), 32'hEB);
      chk("big_csum", 32'(qk[b+5102]), 32'(xk));
      bad = 0;
      for (int i = 0; i < 5100; i++) if (qk[b+2+i] !== i[7:0]) bad++;
      chk("big_data_mism", bad, 0);
    end
    chk("big_busy_after", 32'(ifk.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
